keypad_scan_decoder: RTL and testbench



---
 rtl/keypad_scan_decoder.sv | 165 ++++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/keypad_scan_decoder.sv
// Scans a 4x4 active-low matrix keypad one row at a time and debounces whole
// scan frames into a single accepted key code, a one-cycle valid pulse and a held level.
module keypad_scan_decoder #(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic       i_clk,
  input  logic       i_reset_n,
  input  logic [3:0] i_col,
  output logic [3:0] o_row,
  output logic [3:0] o_key,
  output logic       o_key_valid,
  output logic       o_key_held
);

  localparam int PW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, CAND, PRESSED, REL} state_t;

  logic [3:0]    colMeta_q, colSync_q;
  logic [PW-1:0] presc_q;
  logic [1:0]    rowIdx_q;
  logic [3:0]    row_q;
  logic [1:0]    accCnt_q;
  logic [3:0]    accFirst_q;
  state_t        state_q, state_d;
  logic [3:0]    cand_q, cand_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    key_q, key_d;
  logic          valid_q, valid_d;

  logic       tick, frameEnd;
  logic [3:0] pressed;
  logic [2:0] rowHits;
  logic [1:0] firstCol;
  logic [2:0] hitSum;
  logic [1:0] frameCnt;
  logic [3:0] frameFirst;

  assign tick     = (presc_q == PW'(SCAN_DIV - 1));
  assign frameEnd = tick && (rowIdx_q == 2'd3);

  // Merge the current row's sample into the running frame totals; the press
  // count saturates at 2 since only NONE/KEY/MULTI matters.
  always_comb begin
    pressed  = ~colSync_q;
    rowHits  = 3'd0;
    firstCol = 2'd0;
    for (int k = 0; k < 4; k++) begin
      rowHits = rowHits + 3'(pressed[k]);
    end
    for (int k = 3; k >= 0; k--) begin
      if (pressed[k]) firstCol = 2'(k);
    end
    hitSum     = {1'b0, accCnt_q} + rowHits;
    frameCnt   = (hitSum >= 3'd2) ? 2'd2 : hitSum[1:0];
    frameFirst = (accCnt_q == 2'd0) ? {rowIdx_q, firstCol} : accFirst_q;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      colMeta_q  <= 4'b1111;
      colSync_q  <= 4'b1111;
      presc_q    <= '0;
      rowIdx_q   <= 2'd0;
      row_q      <= 4'b1110;
      accCnt_q   <= 2'd0;
      accFirst_q <= 4'd0;
    end else begin
      colMeta_q <= i_col;
      colSync_q <= colMeta_q;
      presc_q   <= tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        rowIdx_q <= rowIdx_q + 2'd1;
        row_q    <= {row_q[2:0], row_q[3]};
        if (rowIdx_q == 2'd3) begin
          accCnt_q   <= 2'd0;
          accFirst_q <= 4'd0;
        end else begin
          accCnt_q   <= frameCnt;
          accFirst_q <= frameFirst;
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      cand_q  <= 4'd0;
      cnt_q   <= '0;
      key_q   <= 4'd0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
      key_q   <= key_d;
      valid_q <= valid_d;
    end
  end

  // Debounce FSM; it only moves on a frame-end tick, using the frame verdict.
  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    key_d   = key_q;
    valid_d = 1'b0;
    if (frameEnd) begin
      unique case (state_q)
        IDLE: begin
          if (frameCnt == 2'd1) begin
            cand_d  = frameFirst;
            cnt_d   = CW'(1);
            state_d = CAND;
          end
        end
        CAND: begin
          if (frameCnt == 2'd1 && frameFirst == cand_q) begin
            if (cnt_q >= CW'(DEBOUNCE_FRAMES - 1)) begin
              cnt_d   = CW'(DEBOUNCE_FRAMES);
              key_d   = cand_q;
              valid_d = 1'b1;
              state_d = PRESSED;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else if (frameCnt == 2'd1) begin
            cand_d = frameFirst;
            cnt_d  = CW'(1);
          end else begin
            state_d = IDLE;
          end
        end
        PRESSED: begin
          if (frameCnt == 2'd0) begin
            cnt_d   = CW'(1);
            state_d = REL;
          end
        end
        REL: begin
          if (frameCnt == 2'd0) begin
            if (cnt_q >= CW'(DEBOUNCE_FRAMES - 1)) begin
              cnt_d   = CW'(DEBOUNCE_FRAMES);
              state_d = IDLE;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end else begin
            state_d = PRESSED;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign o_row       = row_q;
  assign o_key       = key_q;
  assign o_key_valid = valid_q;
  assign o_key_held  = (state_q == PRESSED) || (state_q == REL);

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Directed bench: a behavioural 4x4 keypad answers the row strobe from a key mask,
// frame-aligned vectors check pulses, key code and held level.
module tb_keypad_scan_decoder;

  logic       clk;
  logic       resetN;
  logic [3:0] col;
  logic [3:0] row;
  logic [3:0] key;
  logic       keyValid;
  logic       keyHeld;
  logic [15:0] keyMask;

  int errors = 0;
  int checks = 0;

  keypad_scan_decoder #(.SCAN_DIV(4), .DEBOUNCE_FRAMES(3)) dut (
    .i_clk      (clk),
    .i_reset_n  (resetN),
    .i_col      (col),
    .o_row      (row),
    .o_key      (key),
    .o_key_valid(keyValid),
    .o_key_held (keyHeld)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // A column reads low when any strobed row has a pressed key in that column.
  always_comb begin
    col = 4'b1111;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (!row[r] && keyMask[r*4+c]) col[c] = 1'b0;
      end
    end
  end

  typedef struct {
    logic [15:0] mask;
    int          frames;
    int          expPulses;
    logic [3:0]  expKey;
    logic        expHeld;
  } vec_t;

  vec_t vecs[18];

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    int pulses = 0;
    keyMask = v.mask;
    repeat (v.frames * 16) begin
      @(negedge clk);
      if (keyValid) pulses++;
    end
    checkOutput($sformatf("vec%0d pulses", idx), pulses, v.expPulses);
    checkOutput($sformatf("vec%0d key", idx), int'(key), int'(v.expKey));
    checkOutput($sformatf("vec%0d held", idx), int'(keyHeld), int'(v.expHeld));
  endtask

  initial begin
    bit aligned;
    logic [3:0] prevRow;
    logic [3:0] expRow;

    vecs[0]  = '{16'h0000, 2, 0, 4'd0,  1'b0};
    vecs[1]  = '{16'h0040, 5, 1, 4'd6,  1'b1};
    vecs[2]  = '{16'h0000, 2, 0, 4'd6,  1'b1};
    vecs[3]  = '{16'h0040, 1, 0, 4'd6,  1'b1};
    vecs[4]  = '{16'h0000, 3, 0, 4'd6,  1'b0};
    vecs[5]  = '{16'h0040, 2, 0, 4'd6,  1'b0};
    vecs[6]  = '{16'h0000, 1, 0, 4'd6,  1'b0};
    vecs[7]  = '{16'h0040, 2, 0, 4'd6,  1'b0};
    vecs[8]  = '{16'h0000, 3, 0, 4'd6,  1'b0};
    vecs[9]  = '{16'h8001, 6, 0, 4'd6,  1'b0};
    vecs[10] = '{16'h0001, 3, 1, 4'd0,  1'b1};
    vecs[11] = '{16'h0000, 3, 0, 4'd0,  1'b0};
    vecs[12] = '{16'h8000, 4, 1, 4'd15, 1'b1};
    vecs[13] = '{16'h0000, 3, 0, 4'd15, 1'b0};
    vecs[14] = '{16'h0001, 3, 1, 4'd0,  1'b1};
    vecs[15] = '{16'h0020, 2, 0, 4'd0,  1'b1};
    vecs[16] = '{16'h0000, 3, 0, 4'd0,  1'b0};
    vecs[17] = '{16'h0200, 4, 1, 4'd9,  1'b1};

    keyMask = 16'h0000;
    resetN  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset row", int'(row), 4'b1110);
    checkOutput("reset key", int'(key), 0);
    checkOutput("reset valid", int'(keyValid), 0);
    checkOutput("reset held", int'(keyHeld), 0);
    resetN = 1'b1;

    aligned = 1'b0;
    prevRow = row;
    for (int i = 0; i < 64 && !aligned; i++) begin
      @(negedge clk);
      if (prevRow == 4'b0111 && row == 4'b1110) aligned = 1'b1;
      prevRow = row;
    end
    checkOutput("frame align", int'(aligned), 1);

    if (aligned) begin
      for (int i = 0; i < 18; i++) applyStimulus(vecs[i], i);

      // Key 9 is held; a reset partway through a frame must clear everything at once.
      repeat (6) @(negedge clk);
      resetN = 1'b0;
      #1;
      checkOutput("midreset row", int'(row), 4'b1110);
      checkOutput("midreset key", int'(key), 0);
      checkOutput("midreset valid", int'(keyValid), 0);
      checkOutput("midreset held", int'(keyHeld), 0);
      keyMask = 16'h0000;
      repeat (2) @(negedge clk);
      resetN = 1'b1;
      for (int k = 1; k <= 16; k++) begin
        @(negedge clk);
        case ((k / 4) % 4)
          0: expRow = 4'b1110;
          1: expRow = 4'b1101;
          2: expRow = 4'b1011;
          default: expRow = 4'b0111;
        endcase
        if (k % 4 == 0 || k == 1 || k == 3)
          checkOutput($sformatf("row step %0d", k), int'(row), int'(expRow));
      end
      checkOutput("post reset held", int'(keyHeld), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
